// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU sequencer.
// Opcode indices, one-hot ALU selects and FSM state encoding.
package alu_pkg;

    localparam int OP_W  = 4;
    localparam int SEL_W = 12;

    localparam logic [OP_W-1:0] OP_AND    = 4'd0;
    localparam logic [OP_W-1:0] OP_OR     = 4'd1;
    localparam logic [OP_W-1:0] OP_NOT    = 4'd2;
    localparam logic [OP_W-1:0] OP_XOR    = 4'd3;
    localparam logic [OP_W-1:0] OP_NAND   = 4'd4;
    localparam logic [OP_W-1:0] OP_NOR    = 4'd5;
    localparam logic [OP_W-1:0] OP_XNOR   = 4'd6;
    localparam logic [OP_W-1:0] OP_ADD    = 4'd7;
    localparam logic [OP_W-1:0] OP_SUB    = 4'd8;
    localparam logic [OP_W-1:0] OP_SHR    = 4'd9;
    localparam logic [OP_W-1:0] OP_SHL    = 4'd10;
    localparam logic [OP_W-1:0] OP_CLEAR  = 4'd11;
    // Opcodes from here up to the top of the field are illegal.
    localparam logic [OP_W-1:0] OP_ILL_LO = 4'd12;

    localparam logic [SEL_W-1:0] SEL_AND   = 12'h001;
    localparam logic [SEL_W-1:0] SEL_OR    = 12'h002;
    localparam logic [SEL_W-1:0] SEL_NOT   = 12'h004;
    localparam logic [SEL_W-1:0] SEL_XOR   = 12'h008;
    localparam logic [SEL_W-1:0] SEL_NAND  = 12'h010;
    localparam logic [SEL_W-1:0] SEL_NOR   = 12'h020;
    localparam logic [SEL_W-1:0] SEL_XNOR  = 12'h040;
    localparam logic [SEL_W-1:0] SEL_ADD   = 12'h080;
    localparam logic [SEL_W-1:0] SEL_SUB   = 12'h100;
    localparam logic [SEL_W-1:0] SEL_SHR   = 12'h200;
    localparam logic [SEL_W-1:0] SEL_SHL   = 12'h400;
    localparam logic [SEL_W-1:0] SEL_CLEAR = 12'h800;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_RESP  = 2'd2;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: 4-bit opcode to one-hot ALU select.
// Purely combinational; illegal opcodes give a zero select.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]  op_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             illegal_o
);

    // Map each legal opcode to its select line, flag the rest.
    always_comb begin
        sel_o     = '0;
        illegal_o = 1'b0;
        unique case (1'b1)
            (op_i == OP_AND):   sel_o = SEL_AND;
            (op_i == OP_OR):    sel_o = SEL_OR;
            (op_i == OP_NOT):   sel_o = SEL_NOT;
            (op_i == OP_XOR):   sel_o = SEL_XOR;
            (op_i == OP_NAND):  sel_o = SEL_NAND;
            (op_i == OP_NOR):   sel_o = SEL_NOR;
            (op_i == OP_XNOR):  sel_o = SEL_XNOR;
            (op_i == OP_ADD):   sel_o = SEL_ADD;
            (op_i == OP_SUB):   sel_o = SEL_SUB;
            (op_i == OP_SHR):   sel_o = SEL_SHR;
            (op_i == OP_SHL):   sel_o = SEL_SHL;
            (op_i == OP_CLEAR): sel_o = SEL_CLEAR;
            default:            illegal_o = (op_i >= OP_ILL_LO);
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: drives an external ALU for one command at a time.
// IDLE accepts, ISSUE holds select/operands, RESP holds the result.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] acc,
    output logic             busy
);

    // ISSUE lasts CNT_INIT+1 cycles; capture happens when the count hits 0.
    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               err_q, err_d;

    logic [SEL_W-1:0]   dec_sel;
    logic               dec_ill;
    logic [WIDTH-1:0]   cap;

    alu_op_decode u_dec (
        .op_i      (cmd_op),
        .sel_o     (dec_sel),
        .illegal_o (dec_ill)
    );

    // CLEAR ignores whatever the ALU drives and forces zero.
    assign cap = (sel_q == SEL_CLEAR) ? '0 : alu_res;

    // Next-state and datapath update for the three-state sequencer.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    sel_d = dec_sel;
                    a_d   = cmd_use_acc ? acc_q : cmd_a;
                    b_d   = cmd_b;
                    if (dec_ill) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (cnt_q == 4'd0) begin
                    data_d  = cap;
                    acc_d   = cap;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign alu_sel   = (state_q == ST_ISSUE) ? sel_q : '0;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign acc       = acc_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign rsp_zero  = (data_q == '0);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: two sequencers (ALU_LAT 1 and 3) against a
// timeline model, plus hand-computed expectations.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [1:0]    cmd_valid = 2'b00;
    logic [3:0]    cmd_op = 4'd0;
    logic [W-1:0]  cmd_a = '0;
    logic [W-1:0]  cmd_b = '0;
    logic          cmd_use_acc = 1'b0;
    logic          rsp_ready = 1'b1;

    logic [1:0]    cmd_ready, rsp_valid, rsp_err, rsp_zero, busy;
    logic [W-1:0]  alu_a [2];
    logic [W-1:0]  alu_b [2];
    logic [W-1:0]  alu_res [2];
    logic [W-1:0]  rsp_data [2];
    logic [W-1:0]  acc [2];
    logic [11:0]   alu_sel [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Result an op index must produce on W-bit operands.
    function automatic logic [W-1:0] golden(int op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            0:  return a & b;
            1:  return a | b;
            2:  return ~a;
            3:  return a ^ b;
            4:  return ~(a & b);
            5:  return ~(a | b);
            6:  return ~(a ^ b);
            7:  return a + b;
            8:  return a - b;
            9:  return a >> 1;
            10: return a << 1;
            default: return '0;
        endcase
    endfunction

    // External ALU: CLEAR and "no select" drive junk on purpose.
    function automatic logic [W-1:0] ext_alu(logic [11:0] sel, logic [W-1:0] a, logic [W-1:0] b);
        int idx;
        idx = -1;
        for (int k = 0; k < 12; k++) if (sel[k]) idx = k;
        if (idx == 11) return 16'hDEAD;
        if (idx < 0) return 16'hBEEF;
        return golden(idx, a, b);
    endfunction

    assign alu_res[0] = ext_alu(alu_sel[0], alu_a[0], alu_b[0]);
    assign alu_res[1] = ext_alu(alu_sel[1], alu_a[1], alu_b[1]);

    alu_sequencer #(.WIDTH(W), .ALU_LAT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]),
        .alu_res(alu_res[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
        .rsp_zero(rsp_zero[0]), .acc(acc[0]), .busy(busy[0])
    );

    alu_sequencer #(.WIDTH(W), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]),
        .alu_res(alu_res[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
        .rsp_zero(rsp_zero[1]), .acc(acc[1]), .busy(busy[1])
    );

    task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", name, i, $time, act, exp);
        end
    endtask

    // Model: per DUT, one outstanding command described by its accept
    // edge number, response latency and expected result.
    int           cyc = 0;
    bit           pend [2];
    bit           ill [2];
    bit           got [2];
    int           t0 [2];
    int           elat [2];
    int           hs_cyc [2];
    logic [W-1:0] mres [2];
    logic [W-1:0] macc [2];
    logic [W-1:0] ma [2];
    logic [W-1:0] mb [2];
    logic [11:0]  msel [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; ill[i] = 0; got[i] = 0; t0[i] = 0; elat[i] = 0;
            hs_cyc[i] = 0; mres[i] = '0; macc[i] = '0; ma[i] = '0;
            mb[i] = '0; msel[i] = '0;
        end
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                for (int i = 0; i < 2; i++) begin
                    pend[i] = 0; macc[i] = '0; ma[i] = '0; mb[i] = '0;
                end
            end else begin
                cyc++;
                for (int i = 0; i < 2; i++) begin
                    if (pend[i]) begin
                        if ((cyc - 1 - t0[i]) >= elat[i] && rsp_ready) begin
                            pend[i] = 0;
                            hs_cyc[i] = cyc;
                            if (!ill[i]) macc[i] = mres[i];
                        end
                    end else if (cmd_valid[i]) begin
                        pend[i] = 1;
                        got[i]  = 1;
                        t0[i]   = cyc;
                        ill[i]  = (cmd_op > 4'd11);
                        elat[i] = ill[i] ? 0 : lat_of(i);
                        ma[i]   = cmd_use_acc ? macc[i] : cmd_a;
                        mb[i]   = cmd_b;
                        msel[i] = ill[i] ? 12'h000 : 12'(1 << cmd_op);
                        mres[i] = ill[i] ? '0 : golden(int'(cmd_op), ma[i], mb[i]);
                    end
                end
            end
        end
    end

    // Select activity recorded per command for literal checks.
    int           selcnt [2];
    logic [11:0]  selval [2];
    logic [W-1:0] sela [2];

    // Compare process: every falling edge, both DUTs.
    initial begin
        int  d;
        bit  e_issue, e_resp;
        for (int i = 0; i < 2; i++) begin
            selcnt[i] = 0; selval[i] = '0; sela[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!reset_n) begin
                    chk("rst_sel", i, 32'(alu_sel[i]), 0);
                    chk("rst_valid", i, 32'(rsp_valid[i]), 0);
                    chk("rst_acc", i, 32'(acc[i]), 0);
                    chk("rst_alu_a", i, 32'(alu_a[i]), 0);
                    chk("rst_alu_b", i, 32'(alu_b[i]), 0);
                end else begin
                    d = cyc - t0[i];
                    e_issue = pend[i] && (d < elat[i]);
                    e_resp  = pend[i] && (d >= elat[i]);
                    chk("cmd_ready", i, 32'(cmd_ready[i]), 32'(!pend[i]));
                    chk("busy", i, 32'(busy[i]), 32'(pend[i]));
                    chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(e_resp));
                    chk("alu_sel", i, 32'(alu_sel[i]), e_issue ? 32'(msel[i]) : 0);
                    chk("alu_a", i, 32'(alu_a[i]), 32'(ma[i]));
                    chk("alu_b", i, 32'(alu_b[i]), 32'(mb[i]));
                    chk("acc", i, 32'(acc[i]),
                        (e_resp && !ill[i]) ? 32'(mres[i]) : 32'(macc[i]));
                    if (e_resp) begin
                        chk("rsp_data", i, 32'(rsp_data[i]), 32'(mres[i]));
                        chk("rsp_err", i, 32'(rsp_err[i]), 32'(ill[i]));
                        chk("rsp_zero", i, 32'(rsp_zero[i]), 32'(mres[i] == '0));
                    end
                    if (alu_sel[i] != '0) begin
                        selcnt[i]++;
                        selval[i] = alu_sel[i];
                        sela[i] = alu_a[i];
                    end
                end
            end
        end
    end

    task automatic start_cmd(int op, logic [W-1:0] a, logic [W-1:0] b, bit ua);
        cmd_op = 4'(op);
        cmd_a = a;
        cmd_b = b;
        cmd_use_acc = ua;
        for (int i = 0; i < 2; i++) begin
            got[i] = 0;
            selcnt[i] = 0;
        end
        cmd_valid = 2'b11;
    endtask

    task automatic finish_cmd();
        for (int k = 0; k < 60 && cmd_valid != 2'b00; k++) begin
            @(posedge clk); #2;
            for (int i = 0; i < 2; i++) if (got[i]) cmd_valid[i] = 1'b0;
        end
        chk("accept_timeout", 0, 32'(cmd_valid), 0);
        cmd_valid = 2'b00;
    endtask

    task automatic send(int op, logic [W-1:0] a, logic [W-1:0] b, bit ua);
        start_cmd(op, a, b, ua);
        finish_cmd();
    endtask

    task automatic wait_resp();
        for (int k = 0; k < 60 && !(rsp_valid[0] && rsp_valid[1]); k++) begin
            @(posedge clk); #2;
        end
        chk("resp_timeout", 0, 32'(rsp_valid), 32'h3);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && (pend[0] || pend[1]); k++) begin
            @(posedge clk); #2;
        end
        chk("idle_timeout", 0, 32'(pend[0] || pend[1]), 0);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    typedef struct {
        int           op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           ua;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0,  16'hA5A5, 16'h0FF0, 1'b0, 16'h05A0};
        tbl[1]  = '{1,  16'hA500, 16'h005A, 1'b0, 16'hA55A};
        tbl[2]  = '{2,  16'h00FF, 16'h0000, 1'b0, 16'hFF00};
        tbl[3]  = '{3,  16'hFFFF, 16'h1234, 1'b0, 16'hEDCB};
        tbl[4]  = '{4,  16'hF0F0, 16'hFF00, 1'b0, 16'h0FFF};
        tbl[5]  = '{5,  16'h0F00, 16'h00F0, 1'b0, 16'hF00F};
        tbl[6]  = '{6,  16'h1234, 16'h1234, 1'b0, 16'hFFFF};
        tbl[7]  = '{7,  16'hFFFF, 16'h0002, 1'b0, 16'h0001};
        tbl[8]  = '{8,  16'h0000, 16'h0001, 1'b0, 16'hFFFF};
        tbl[9]  = '{9,  16'h8001, 16'h0000, 1'b0, 16'h4000};
        tbl[10] = '{10, 16'h8001, 16'h0000, 1'b0, 16'h0002};
        tbl[11] = '{7,  16'h0000, 16'h0005, 1'b1, 16'h0007};

        #1 reset_n = 1'b0;
        step(3);
        for (int i = 0; i < 2; i++) begin
            chk("in_rst_acc", i, 32'(acc[i]), 0);
            chk("in_rst_data", i, 32'(rsp_data[i]), 0);
            chk("in_rst_err", i, 32'(rsp_err[i]), 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk("post_rst_ready", i, 32'(cmd_ready[i]), 1);
        step(1);

        // ADD 3+4, then hold the response for five cycles
        rsp_ready = 1'b0;
        send(7, 16'h0003, 16'h0004, 1'b0);
        wait_resp();
        for (int i = 0; i < 2; i++) begin
            chk("add_data", i, 32'(rsp_data[i]), 32'h7);
            chk("add_acc", i, 32'(acc[i]), 32'h7);
            chk("add_err", i, 32'(rsp_err[i]), 0);
            chk("add_sel", i, 32'(selval[i]), 32'h080);
            chk("add_sel_cycles", i, selcnt[i], lat_of(i));
        end
        step(5);
        for (int i = 0; i < 2; i++) begin
            chk("stall_ready", i, 32'(cmd_ready[i]), 0);
            chk("stall_busy", i, 32'(busy[i]), 1);
            chk("stall_valid", i, 32'(rsp_valid[i]), 1);
            chk("stall_data", i, 32'(rsp_data[i]), 32'h7);
        end
        rsp_ready = 1'b1;
        wait_idle();

        // SUB with accumulator as A
        rsp_ready = 1'b0;
        send(8, 16'h0000, 16'h0002, 1'b1);
        wait_resp();
        for (int i = 0; i < 2; i++) begin
            chk("sub_alu_a", i, 32'(sela[i]), 32'h7);
            chk("sub_data", i, 32'(rsp_data[i]), 32'h5);
            chk("sub_acc", i, 32'(acc[i]), 32'h5);
            chk("sub_sel", i, 32'(selval[i]), 32'h100);
            chk("sub_sel_cycles", i, selcnt[i], lat_of(i));
        end
        rsp_ready = 1'b1;
        wait_idle();

        // Illegal opcode: response right after the accepting edge
        rsp_ready = 1'b0;
        send(13, 16'h1111, 16'h2222, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("ill_valid", i, 32'(rsp_valid[i]), 1);
            chk("ill_err", i, 32'(rsp_err[i]), 1);
            chk("ill_data", i, 32'(rsp_data[i]), 0);
            chk("ill_acc", i, 32'(acc[i]), 32'h5);
        end
        step(2);
        for (int i = 0; i < 2; i++) chk("ill_sel_cycles", i, selcnt[i], 0);
        rsp_ready = 1'b1;
        wait_idle();

        // Table of operations through both sequencers
        foreach (tbl[n]) begin
            send(tbl[n].op, tbl[n].a, tbl[n].b, tbl[n].ua);
            wait_idle();
            for (int i = 0; i < 2; i++) chk("tbl_acc", i, 32'(acc[i]), 32'(tbl[n].exp));
        end

        // Next command waiting while the response is stalled
        rsp_ready = 1'b0;
        send(1, 16'h0F0F, 16'hF000, 1'b0);
        wait_resp();
        step(5);
        start_cmd(3, 16'h00FF, 16'h0F0F, 1'b0);
        rsp_ready = 1'b1;
        finish_cmd();
        for (int i = 0; i < 2; i++) chk("b2b_accept_edge", i, t0[i], hs_cyc[i] + 1);
        wait_idle();
        for (int i = 0; i < 2; i++) chk("b2b_acc", i, 32'(acc[i]), 32'h0FF0);

        // Asynchronous reset in the middle of ISSUE
        send(1, 16'h1234, 16'h0000, 1'b0);
        wait_idle();
        for (int i = 0; i < 2; i++) chk("pre_rst_acc", i, 32'(acc[i]), 32'h1234);
        send(7, 16'h0000, 16'h0001, 1'b1);
        for (int i = 0; i < 2; i++) chk("pre_rst_sel", i, 32'(alu_sel[i]), 32'h080);
        #1 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_sel", i, 32'(alu_sel[i]), 0);
            chk("async_valid", i, 32'(rsp_valid[i]), 0);
            chk("async_acc", i, 32'(acc[i]), 0);
            chk("async_busy", i, 32'(busy[i]), 0);
            chk("async_alu_a", i, 32'(alu_a[i]), 0);
        end
        #2 reset_n = 1'b1;
        step(1);
        for (int i = 0; i < 2; i++) chk("rerst_ready", i, 32'(cmd_ready[i]), 1);

        // CLEAR from a nonzero accumulator
        send(1, 16'h00FF, 16'h0000, 1'b0);
        wait_idle();
        for (int i = 0; i < 2; i++) chk("pre_clr_acc", i, 32'(acc[i]), 32'h00FF);
        rsp_ready = 1'b0;
        send(11, 16'h5555, 16'h3333, 1'b0);
        wait_resp();
        for (int i = 0; i < 2; i++) begin
            chk("clr_acc", i, 32'(acc[i]), 0);
            chk("clr_data", i, 32'(rsp_data[i]), 0);
            chk("clr_zero", i, 32'(rsp_zero[i]), 1);
            chk("clr_err", i, 32'(rsp_err[i]), 0);
        end
        rsp_ready = 1'b1;
        wait_idle();

        step(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width.
REQ-002 SHALL have parameter ALU_LAT, default 1, legal 1..15, cycles ALU output needs to settle after select/operands are stable.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 cmd_op  input  4  operation index: 0 AND, 1 OR, 2 NOT, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 ADD, 8 SUB, 9 SHRIGHT, 10 SHLEFT, 11 CLEAR; 12..15 illegal.
REQ-008 cmd_a, cmd_b  input  WIDTH each  operands.
REQ-009 cmd_use_acc  input  1  substitute accumulator for operand A.
REQ-010 alu_a, alu_b  output  WIDTH each  operands to ALU.
REQ-011 alu_sel  output  12  one-hot ALU select, bit n = operation index n.
REQ-012 alu_res  input  WIDTH  ALU result.
REQ-013 rsp_valid  output  1 / rsp_ready  input  1  response handshake.
REQ-014 rsp_data  output  WIDTH  captured result; rsp_err  output  1  illegal opcode; rsp_zero  output  1  rsp_data == 0.
REQ-015 acc  output  WIDTH  accumulator; busy  output  1  state != IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-017 IDLE: cmd_ready=1; on cmd_valid=1 SHALL latch op, operands, use_acc; legal op -> ISSUE, illegal op -> RESP with rsp_err=1, rsp_data=0, acc unchanged.
REQ-018 cmd_ready SHALL be 0 in ISSUE and RESP; no command overlap.
REQ-019 ISSUE: alu_sel = one-hot of latched op, alu_a = acc (if use_acc) else latched a, alu_b = latched b, all stable for exactly ALU_LAT cycles via down-counter.
REQ-020 On the last ISSUE cycle SHALL capture alu_res into rsp_data and acc, rsp_err=0, then -> RESP.
REQ-021 CLEAR SHALL set acc=0 and rsp_data=0 regardless of alu_res.
REQ-022 Latency: rsp_valid SHALL first be high ALU_LAT+1 cycles after the accepting edge (legal op), 1 cycle after (illegal op).
REQ-023 RESP: rsp_valid=1; rsp_data/rsp_err/rsp_zero stable until rsp_valid&&rsp_ready, then -> IDLE.
REQ-024 alu_sel SHALL be 12'h000 outside ISSUE; alu_a/alu_b hold last values.
REQ-025 acc value used for use_acc SHALL be the value at acceptance; acc changes only at capture or reset.
REQ-026 Arithmetic is external; no width growth; capture is truncating WIDTH bits.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, acc=0, rsp_data=0, rsp_err=0, rsp_valid=0, alu_sel=0, alu_a=0, alu_b=0, counter=0, including mid-ISSUE or mid-RESP; pending command discarded.
REQ-028 cmd_ready SHALL be 1 from the first cycle after reset_n deasserts.

Structure
REQ-029 Shared package alu_pkg SHALL hold operation index constants, 12-bit one-hot select constants, illegal-op range, and FSM state type.
REQ-030 Sub-module alu_op_decode SHALL map 4-bit op to 12-bit one-hot plus illegal flag; combinational only.
REQ-031 Target 120-400 lines RTL total.

Verification (bench ALU model, ALU_LAT=1 unless stated)
REQ-032 ADD op 7, a=0x0003, b=0x0004 -> alu_sel=0x080 for 1 cycle, rsp_data=0x0007, acc=0x0007, rsp_err=0.
REQ-033 Then SUB op 8, use_acc=1, b=0x0002 -> alu_a=0x0007, rsp_data=0x0005, acc=0x0005; ALU_LAT=3 variant holds alu_sel=0x100 exactly 3 cycles.
REQ-034 Illegal op 13 -> rsp_valid next cycle, rsp_err=1, rsp_data=0, alu_sel never nonzero, acc unchanged.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data stable, cmd_ready=0, busy=1; accepts next command the cycle after handshake.
REQ-036 reset_n pulsed low during ISSUE with acc=0x1234 -> alu_sel=0, rsp_valid=0, acc=0 asynchronously; CLEAR op 11 from acc=0x00FF -> acc=0, rsp_zero=1.
